// File: rtl/ahb_sram_ctrl_pkg.sv
// Shared definitions for the AHB-Lite to single-port SRAM bridge:
// transfer encodings, FSM states and lane-selection helpers.
package ahb_sram_ctrl_pkg;

   localparam int         HTRANS_VALID_BIT = 1;
   localparam logic [2:0] HSIZE_BYTE       = 3'd0;
   localparam logic [2:0] HSIZE_HALF       = 3'd1;
   localparam logic [2:0] HSIZE_WORD       = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_ERR1,
      ST_ERR2
   } state_t;

   // Oversized or naturally misaligned transfers are refused with ERROR.
   function automatic logic size_error(input logic [2:0] size, input logic [1:0] offset);
      logic err;
      err = 1'b0;
      if (size > HSIZE_WORD)
         err = 1'b1;
      else if (size == HSIZE_WORD && offset != 2'd0)
         err = 1'b1;
      else if (size == HSIZE_HALF && offset[0])
         err = 1'b1;
      return err;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
      logic [3:0] mask;
      case (size)
         HSIZE_BYTE: mask = 4'b0001 << offset;
         HSIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
         default:    mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ahb_sram_wmerge.sv
// Byte-lane merge for sub-word writes: lanes addressed by the transfer come
// from hwdata, all other lanes keep the word read back from the RAM.
module ahb_sram_wmerge
   import ahb_sram_ctrl_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  size,
   output logic [31:0] merged
);

   logic [3:0] mask;

   always_comb begin
      mask   = lane_mask(size, offset);
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mask[i])
            merged[8*i +: 8] = wdata[8*i +: 8];
      end
   end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave driving a single-port synchronous RAM: zero-wait reads,
// one-cycle word writes, read-modify-write for byte/halfword writes.
module ahb_sram_ctrl
   import ahb_sram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  hsel,
   input  logic [31:0]           haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [31:0]           hwdata,
   input  logic                  hready,
   output logic                  hreadyout,
   output logic                  hresp,
   output logic [31:0]           hrdata,
   output logic                  ram_cen,
   output logic                  ram_wen,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_data,
   input  logic [31:0]           ram_q
);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [1:0]            wr_offset;
   logic [2:0]            wr_size;
   logic                  rd_dphase;
   logic                  pending, accept, accept_rd, err_req;
   logic [31:0]           merged;

   // Upper address bits alias the RAM window, and only htrans[1] qualifies a transfer.
   logic unused_ok;
   assign unused_ok = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

   assign pending = hsel & htrans[HTRANS_VALID_BIT];
   assign accept  = pending & hready;
   assign err_req = size_error(hsize, haddr[1:0]);

   ahb_sram_wmerge u_wmerge (
      .old_word (ram_q),
      .wdata    (hwdata),
      .offset   (wr_offset),
      .size     (wr_size),
      .merged   (merged)
   );

   always_comb begin
      state_nxt = state;
      hreadyout = 1'b1;
      hresp     = 1'b0;
      ram_cen   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = '0;
      ram_data  = '0;
      accept_rd = 1'b0;
      case (state)
         ST_IDLE, ST_ERR2: begin
            hresp     = (state == ST_ERR2);
            state_nxt = ST_IDLE;
            if (accept) begin
               if (err_req)
                  state_nxt = ST_ERR1;
               else if (!hwrite) begin
                  // Reads are issued straight from the address phase so data is back next cycle.
                  accept_rd = 1'b1;
                  ram_cen   = 1'b1;
                  ram_addr  = haddr[ADDR_WIDTH+1:2];
               end else if (hsize == HSIZE_WORD)
                  state_nxt = ST_WR;
               else
                  state_nxt = ST_RMW_RD;
            end
         end
         ST_WR: begin
            ram_cen   = 1'b1;
            ram_wen   = 1'b1;
            ram_addr  = wr_addr;
            ram_data  = hwdata;
            // Hold off a following transfer so a read never collides with this write.
            hreadyout = !pending;
            state_nxt = ST_IDLE;
         end
         ST_RMW_RD: begin
            ram_cen   = 1'b1;
            ram_addr  = wr_addr;
            hreadyout = 1'b0;
            state_nxt = ST_RMW_WR;
         end
         ST_RMW_WR: begin
            ram_cen   = 1'b1;
            ram_wen   = 1'b1;
            ram_addr  = wr_addr;
            ram_data  = merged;
            hreadyout = !pending;
            state_nxt = ST_IDLE;
         end
         ST_ERR1: begin
            hresp     = 1'b1;
            hreadyout = 1'b0;
            state_nxt = ST_ERR2;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         rd_dphase <= 1'b0;
      end else begin
         state     <= state_nxt;
         rd_dphase <= accept_rd;
      end
   end

   // Address-phase capture; meaningful only while a write data phase is active.
   always_ff @(posedge clk) begin
      if (accept) begin
         wr_addr   <= haddr[ADDR_WIDTH+1:2];
         wr_offset <= haddr[1:0];
         wr_size   <= hsize;
      end
   end

   assign hrdata = rd_dphase ? ram_q : 32'h0;

endmodule
